// File: rtl/aux_input_conditioner.sv
// aux_input_conditioner: synchronizes and debounces the resume button and switch bank onto clk.
module aux_input_conditioner #(
   parameter int SwtBit      = 16,
   parameter int SyncStages  = 2,
   parameter int DebounceCnt = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_raw,
   input  logic [SwtBit-1:0] swt_raw,
   output logic              btn_level,
   output logic              btn_press,
   output logic              btn_release,
   output logic [SwtBit-1:0] swt_stable,
   output logic [SwtBit-1:0] swt_toggled,
   output logic              swt_changed
);
   localparam int CW = $clog2(DebounceCnt) + 1;
   localparam logic [CW-1:0] LAST = CW'(DebounceCnt - 1);
   typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;
   logic [SyncStages-1:0]             btn_sync_q;
   logic [SyncStages-1:0][SwtBit-1:0] swt_sync_q;
   logic                              btn_sync;
   logic [SwtBit-1:0]                 swt_sync;
   state_t                            state_q, state_d;
   logic [CW-1:0]                     bcnt_q, bcnt_d, scnt_q, scnt_d;
   logic                              press_q, press_d, release_q, release_d, level_q, level_d;
   logic [SwtBit-1:0]                 cand_q, cand_d, stable_q, stable_d, toggled_q, toggled_d;
   logic                              changed_q;
   assign btn_sync = btn_sync_q[SyncStages-1];
   assign swt_sync = swt_sync_q[SyncStages-1];
   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         S_LOW:
            if (btn_sync) begin
               if (DebounceCnt == 1) begin
                  state_d = S_HIGH;
                  press_d = 1'b1;
               end else begin
                  state_d = S_RISE;
                  bcnt_d  = CW'(1);
               end
            end
         S_RISE:
            if (!btn_sync) begin
               state_d = S_LOW;
               bcnt_d  = '0;
            end else if (bcnt_q == LAST) begin
               state_d = S_HIGH;
               press_d = 1'b1;
               bcnt_d  = '0;
            end else bcnt_d = bcnt_q + 1'b1;
         S_HIGH:
            if (!btn_sync) begin
               if (DebounceCnt == 1) begin
                  state_d   = S_LOW;
                  release_d = 1'b1;
               end else begin
                  state_d = S_FALL;
                  bcnt_d  = CW'(1);
               end
            end
         S_FALL:
            if (btn_sync) begin
               state_d = S_HIGH;
               bcnt_d  = '0;
            end else if (bcnt_q == LAST) begin
               state_d   = S_LOW;
               release_d = 1'b1;
               bcnt_d    = '0;
            end else bcnt_d = bcnt_q + 1'b1;
      endcase
      level_d = (state_d == S_HIGH) || (state_d == S_FALL);
   end
   // Any moving switch bit restarts the single shared window for the whole bank.
   always_comb begin
      cand_d    = cand_q;
      scnt_d    = '0;
      stable_d  = stable_q;
      toggled_d = '0;
      if (swt_sync != cand_q) cand_d = swt_sync;
      else if (cand_q != stable_q) begin
         if (scnt_q == LAST) begin
            stable_d  = cand_q;
            toggled_d = stable_q ^ cand_q;
         end else scnt_d = scnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_sync_q <= '0;
         swt_sync_q <= '0;
         state_q    <= S_LOW;
         bcnt_q     <= '0;
         scnt_q     <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         level_q    <= 1'b0;
         cand_q     <= '0;
         stable_q   <= '0;
         toggled_q  <= '0;
         changed_q  <= 1'b0;
      end else begin
         btn_sync_q <= {btn_sync_q[SyncStages-2:0], btn_raw};
         swt_sync_q <= {swt_sync_q[SyncStages-2:0], swt_raw};
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         scnt_q     <= scnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         level_q    <= level_d;
         cand_q     <= cand_d;
         stable_q   <= stable_d;
         toggled_q  <= toggled_d;
         changed_q  <= |toggled_d;
      end
   end
   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign swt_stable  = stable_q;
   assign swt_toggled = toggled_q;
   assign swt_changed = changed_q;
endmodule
